// File: rtl/gcm_pkg.sv
// gcm_pkg: shared state encoding and length limits for the GCM length tracker.
package gcm_pkg;
  typedef enum logic [2:0] {IDLE, AAD, CT, EMIT, ERR} state_t;
  localparam int BEAT_BYTES = 16;
  localparam int AAD_W = 61;
  localparam int CT_W = 36;
  localparam logic [AAD_W-1:0] AAD_LIMIT = '1;
  localparam logic [CT_W-1:0] CT_LIMIT = 36'hF_FFFF_FFE0;
endpackage

// File: rtl/gcm_len_counter.sv
// gcm_len_counter: byte counter with clear, add and limit-overflow detection.
module gcm_len_counter #(
  parameter int W = 36,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [4:0]   add,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  logic [W:0] sum;
  // one extra bit so an all-ones limit can still be exceeded
  assign sum = {1'b0, cnt} + {{(W-4){1'b0}}, add};
  assign ovf = sum > {1'b0, LIMIT};
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (add_en) cnt <= sum[W-1:0];
endmodule

// File: rtl/gcm_len_tracker.sv
// gcm_len_tracker: counts AAD/CT bytes of a GCM message and emits the
// {len(A), len(C)} bit-length block toward GHASH.
module gcm_len_tracker
  import gcm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         aad_valid,
  input  logic         aad_last,
  input  logic [4:0]   aad_bytes,
  output logic         aad_ready,
  input  logic         ct_valid,
  input  logic         ct_last,
  input  logic [4:0]   ct_bytes,
  output logic         ct_ready,
  output logic         len_valid,
  input  logic         len_ready,
  output logic [127:0] len_block,
  output logic [63:0]  len_aad_bits,
  output logic [63:0]  len_ct_bits,
  output logic         err
);
  state_t state, nxt;
  logic aad_acc, ct_acc, aad_bad, ct_bad, aad_ovf, ct_ovf;
  logic [AAD_W-1:0] aad_cnt;
  logic [CT_W-1:0] ct_cnt;
  assign aad_ready = state == AAD && !start;
  assign ct_ready = (state == CT || (state == AAD && !aad_valid)) && !start;
  assign aad_acc = aad_valid && aad_ready;
  assign ct_acc = ct_valid && ct_ready;
  // only the final beat of a phase may be short
  assign aad_bad = aad_bytes > 5'(BEAT_BYTES) || (!aad_last && aad_bytes != 5'(BEAT_BYTES)) || aad_ovf;
  assign ct_bad = ct_bytes > 5'(BEAT_BYTES) || (!ct_last && ct_bytes != 5'(BEAT_BYTES)) || ct_ovf;
  gcm_len_counter #(.W(AAD_W), .LIMIT(AAD_LIMIT)) u_aad (
    .clk(clk), .rst(rst), .clr(start), .add_en(aad_acc && !aad_bad),
    .add(aad_bytes), .cnt(aad_cnt), .ovf(aad_ovf)
  );
  gcm_len_counter #(.W(CT_W), .LIMIT(CT_LIMIT)) u_ct (
    .clk(clk), .rst(rst), .clr(start), .add_en(ct_acc && !ct_bad),
    .add(ct_bytes), .cnt(ct_cnt), .ovf(ct_ovf)
  );
  assign len_aad_bits = {aad_cnt, 3'b000};
  assign len_ct_bits = {{(61-CT_W){1'b0}}, ct_cnt, 3'b000};
  assign len_block = {len_aad_bits, len_ct_bits};
  assign len_valid = state == EMIT;
  assign err = state == ERR;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      AAD:  nxt = aad_acc ? (aad_bad ? ERR : aad_last ? CT : AAD)
                : ct_acc ? (ct_bad ? ERR : ct_last ? EMIT : CT) : AAD;
      CT:   nxt = ct_acc ? (ct_bad ? ERR : ct_last ? EMIT : CT) : CT;
      EMIT: nxt = len_ready ? IDLE : EMIT;
      default: nxt = state;
    endcase
    if (start) nxt = AAD;
  end
endmodule

// File: tb/tb_gcm_len_tracker.sv
// tb_gcm_len_tracker: table-driven directed checks plus hand-written
// sequences for EMIT back-pressure and asynchronous reset.
module tb_gcm_len_tracker;
  logic clk = 0, rst = 1, start = 0;
  logic aad_valid = 0, aad_last = 0, ct_valid = 0, ct_last = 0, len_ready = 0;
  logic [4:0] aad_bytes = 0, ct_bytes = 0;
  logic aad_ready, ct_ready, len_valid, err;
  logic [127:0] len_block;
  logic [63:0] len_aad_bits, len_ct_bits;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic st, av, al; logic [4:0] ab;
    logic cv, cl; logic [4:0] cb; logic lr;
    logic ar, cr, lv, er; logic [127:0] blk;
  } vec_t;
  vec_t vq[$];

  gcm_len_tracker dut (
    .clk(clk), .rst(rst), .start(start),
    .aad_valid(aad_valid), .aad_last(aad_last), .aad_bytes(aad_bytes), .aad_ready(aad_ready),
    .ct_valid(ct_valid), .ct_last(ct_last), .ct_bytes(ct_bytes), .ct_ready(ct_ready),
    .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block),
    .len_aad_bits(len_aad_bits), .len_ct_bits(len_ct_bits), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int st, av, al, ab, cv, cl, cb, lr, ar, cr, lv, er, input logic [127:0] blk);
    vec_t v;
    v.st = st[0]; v.av = av[0]; v.al = al[0]; v.ab = 5'(ab);
    v.cv = cv[0]; v.cl = cl[0]; v.cb = 5'(cb); v.lr = lr[0];
    v.ar = ar[0]; v.cr = cr[0]; v.lv = lv[0]; v.er = er[0]; v.blk = blk;
    vq.push_back(v);
  endtask

  task automatic idle_in();
    start = 0; aad_valid = 0; aad_last = 0; aad_bytes = 0;
    ct_valid = 0; ct_last = 0; ct_bytes = 0; len_ready = 0;
  endtask

  task automatic chk_outs(input string tag, input logic ar, cr, lv, er, input logic [127:0] blk);
    chk({tag, " aad_ready"}, 128'(aad_ready), 128'(ar));
    chk({tag, " ct_ready"}, 128'(ct_ready), 128'(cr));
    chk({tag, " len_valid"}, 128'(len_valid), 128'(lv));
    chk({tag, " err"}, 128'(err), 128'(er));
    chk({tag, " len_block"}, len_block, blk);
  endtask

  initial begin
    //   st av al ab cv cl cb lr | ar cr lv er blk
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 128'd0);
    add(0, 1, 0,16, 0, 0, 0, 0,  1, 0, 0, 0, 128'd0);
    add(0, 1, 1, 4, 0, 0, 0, 0,  1, 0, 0, 0, {64'd128, 64'd0});
    add(0, 0, 0, 0, 1, 0,16, 0,  0, 1, 0, 0, {64'd160, 64'd0});
    add(0, 0, 0, 0, 1, 0,16, 0,  0, 1, 0, 0, {64'd160, 64'd128});
    add(0, 0, 0, 0, 1, 1, 7, 0,  0, 1, 0, 0, {64'd160, 64'd256});
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, {64'd160, 64'd312});
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, {64'd160, 64'd312});
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, {64'd160, 64'd312});
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, {64'd160, 64'd312});
    add(0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 128'd0);
    add(0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 128'd0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 128'd0);
    add(0, 0, 0, 0, 1, 1,16, 0,  1, 1, 0, 0, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, {64'd0, 64'd128});
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, {64'd0, 64'd128});
    add(0, 1, 1, 8, 1, 1,16, 0,  1, 0, 0, 0, 128'd0);
    add(0, 0, 0, 0, 1, 1,16, 0,  0, 1, 0, 0, {64'd64, 64'd0});
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, {64'd64, 64'd128});
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, {64'd64, 64'd128});
    add(0, 1, 0, 5, 0, 0, 0, 0,  1, 0, 0, 0, 128'd0);
    add(0, 1, 0,16, 1, 1, 1, 1,  0, 0, 0, 1, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 128'd0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 128'd0);
    add(0, 1, 1,17, 0, 0, 0, 0,  1, 0, 0, 0, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 128'd0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 128'd0);
    add(0, 0, 0, 0, 1, 1,16, 0,  1, 1, 0, 0, 128'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, {64'd0, 64'd128});
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, {64'd0, 64'd128});
    add(0, 1, 1,16, 1, 1,16, 1,  0, 0, 0, 0, {64'd0, 64'd128});
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, {64'd0, 64'd128});

    repeat (2) @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0, 128'd0);
    rst = 0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].st; aad_valid = vq[i].av; aad_last = vq[i].al; aad_bytes = vq[i].ab;
      ct_valid = vq[i].cv; ct_last = vq[i].cl; ct_bytes = vq[i].cb; len_ready = vq[i].lr;
      #1 chk_outs($sformatf("vec%0d", i), vq[i].ar, vq[i].cr, vq[i].lv, vq[i].er, vq[i].blk);
    end

    // EMIT held under back-pressure
    @(negedge clk); idle_in(); start = 1;
    @(negedge clk); idle_in(); ct_valid = 1; ct_last = 1; ct_bytes = 16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle_in();
      #1 chk_outs($sformatf("stall%0d", i), 0, 0, 1, 0, {64'd0, 64'd128});
    end
    @(negedge clk); len_ready = 1;
    #1 chk("stall release len_valid", 128'(len_valid), 128'd1);
    @(negedge clk); idle_in();
    #1 chk("after release len_valid", 128'(len_valid), 128'd0);

    // asynchronous reset in the middle of the CT phase
    @(negedge clk); start = 1;
    @(negedge clk); idle_in(); aad_valid = 1; aad_last = 1; aad_bytes = 16;
    @(negedge clk); idle_in(); ct_valid = 1; ct_bytes = 16;
    @(negedge clk);
    #1 chk("midct ct_ready", 128'(ct_ready), 128'd1);
    chk("midct len_block", len_block, {64'd128, 64'd16 * 8});
    #1 rst = 1;
    #1 chk_outs("async_rst", 0, 0, 0, 0, 128'd0);
    chk("async_rst aad_bits", 128'(len_aad_bits), 128'd0);
    chk("async_rst ct_bits", 128'(len_ct_bits), 128'd0);
    idle_in();
    @(negedge clk); rst = 0; ct_valid = 1; ct_last = 1; ct_bytes = 16; len_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk_outs($sformatf("post_rst%0d", i), 0, 0, 0, 0, 128'd0);
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcm_len_tracker.md
GCM_LEN_TRACKER -- requirements
Module: gcm_len_tracker

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: single-cycle pulse that opens a new message and clears both counters.
REQ-004 SHALL have ports aad_valid (input, 1), aad_last (input, 1), aad_bytes (input, 5) and aad_ready (output, 1): AAD beat handshake; aad_bytes gives valid bytes in the beat, 0..16.
REQ-005 SHALL have ports ct_valid (input, 1), ct_last (input, 1), ct_bytes (input, 5) and ct_ready (output, 1): ciphertext beat handshake, same semantics as AAD.
REQ-006 SHALL have ports len_valid (output, 1), len_ready (input, 1) and len_block (output, 128): length-block handshake toward GHASH.
REQ-007 SHALL have ports len_aad_bits (output, 64) and len_ct_bits (output, 64): running bit counts.
REQ-008 SHALL have port err, output, 1 bit: sticky protocol/limit error flag.

Function
REQ-009 SHALL implement the FSM states IDLE, AAD, CT, EMIT and ERR.
REQ-010 SHALL take start in any state to AAD next cycle, with counters zeroed and err cleared.
REQ-011 SHALL give start priority: beats presented in the start cycle are not counted.
REQ-012 SHALL drive aad_ready = (state==AAD) && !start.
REQ-013 SHALL drive ct_ready = ((state==CT) || (state==AAD && !aad_valid)) && !start.
REQ-014 SHALL define a beat as accepted when valid && ready; only accepted beats change state or counters.
REQ-015 SHALL, in AAD: add aad_bytes to aad_cnt on an accepted AAD beat; move to CT if aad_last.
REQ-016 SHALL, in AAD: treat an accepted CT beat as closing the AAD phase; count it into ct_cnt; go to EMIT if ct_last, else to CT.
REQ-017 SHALL give AAD priority when aad_valid and ct_valid are both high in AAD state; the CT beat waits.
REQ-018 SHALL, in CT: add ct_bytes to ct_cnt on an accepted CT beat; go to EMIT if ct_last.
REQ-019 SHALL allow a last beat with 0 bytes (empty AAD or empty CT terminator).
REQ-020 SHALL assert len_valid only in EMIT, starting the cycle after the accepted ct_last beat (latency 1).
REQ-021 SHALL drive len_block = {len_aad_bits, len_ct_bits}, held stable while len_valid=1.
REQ-022 SHALL go from EMIT to IDLE on len_valid && len_ready.
REQ-023 SHALL keep len_valid asserted while len_ready=0, without bound.
REQ-024 SHALL drive len_aad_bits = aad_cnt<<3 and len_ct_bits = ct_cnt<<3, zero-extended to 64 bits.
REQ-025 SHALL size aad_cnt at 61 bits and ct_cnt at 36 bits.
REQ-026 SHALL raise an error on any of the following: a byte value >16; a non-last beat with bytes<16; aad_cnt exceeding 2^61-1; ct_cnt exceeding 2^36-32.
REQ-027 SHALL, on error: set err next cycle, enter ERR, deassert all readies, never assert len_valid; ERR is left only by start or rst.
REQ-028 SHALL ignore beats presented in IDLE; readies are low in IDLE.

Reset
REQ-029 SHALL, on rst: state=IDLE; aad_cnt=0, ct_cnt=0; len_valid=0, aad_ready=0, ct_ready=0, err=0; len_block=0.
REQ-030 SHALL abort a message in progress when rst asserts mid-message; no length block is emitted for it.

Structure
REQ-031 SHALL place in shared package gcm_pkg: the state enum, the AAD and CT byte-limit constants, and the beat width (16 bytes).
REQ-032 SHALL instantiate sub-module gcm_len_counter twice (parameterised width, clear, add, limit compare, overflow output), once for AAD and once for CT.

Verification
REQ-033 SHALL cover: start; AAD beats 16,4(last); CT beats 16,16,7(last) -> len_valid one cycle after the last CT beat, len_block = {64'd160, 64'd312}.
REQ-034 SHALL cover: start; aad_last with 0 bytes; ct_last with 0 bytes -> len_block = 128'd0, len_valid asserted.
REQ-035 SHALL cover: start; CT beat 16(last) with no AAD beats -> len_block = {64'd0, 64'd128}.
REQ-036 SHALL cover: aad_valid and ct_valid both high in AAD state -> only the AAD beat is accepted; CT is accepted the following cycle after aad_last.
REQ-037 SHALL cover: a non-last AAD beat of 5 bytes -> err=1 next cycle, readies low, len_valid stays 0; then start -> err=0, state AAD.
REQ-038 SHALL cover: EMIT with len_ready=0 for 10 cycles -> len_block stable; rst mid-CT -> all outputs 0 asynchronously.
